dmem_arbiter: RTL and testbench

//  Shares the single-ported DataMemory between two requesters: port 0 = processor load/store path,

---
 rtl/dmem_arbiter.sv | 132 +++++++++++++
 tb/tb_dmem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-ported DataMemory: latches one access,
// holds it on the memory bus for MEM_LAT cycles, then returns a one-cycle response.
module dmem_arbiter #(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned FAIR    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [2:0]  m0_ctrl,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [2:0]  m1_ctrl,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic [2:0]  mem_ctrl,
    input  logic [31:0] mem_rdata
);

    localparam logic [3:0] CntInit = 4'(MEM_LAT - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e      state_q, state_d;
    logic        last_q, last_d;
    logic        port_q, port_d;
    logic        we_q, we_d;
    logic        first_q, first_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        grant;
    logic        busy;
    logic        resp;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        port_d  = port_q;
        we_d    = we_q;
        first_d = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ctrl_d  = ctrl_q;
        cnt_d   = cnt_q;
        // Port 1 wins when alone, or on a tie when round-robin says it is its turn.
        grant   = m1_req && (!m0_req || (FAIR != 0 && !last_q));
        unique case (state_q)
            StIdle: begin
                if (m0_req || m1_req) begin
                    port_d  = grant;
                    last_d  = grant;
                    we_d    = grant ? m1_we    : m0_we;
                    addr_d  = grant ? m1_addr  : m0_addr;
                    wdata_d = grant ? m1_wdata : m0_wdata;
                    ctrl_d  = grant ? m1_ctrl  : m0_ctrl;
                    cnt_d   = CntInit;
                    first_d = 1'b1;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q == 4'd0) begin
                    // Stores never look at mem_rdata, so an undriven bus cannot leak out.
                    rdata_d = we_q ? 32'h0 : mem_rdata;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            first_q <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            ctrl_q  <= 3'h0;
            cnt_q   <= 4'h0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            port_q  <= port_d;
            we_q    <= we_d;
            first_q <= first_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy      = (state_q == StBusy);
    assign resp      = (state_q == StResp);

    assign mem_addr  = busy ? addr_q  : 32'h0;
    assign mem_wdata = busy ? wdata_q : 32'h0;
    assign mem_ctrl  = busy ? ctrl_q  : 3'h0;
    assign mem_we    = busy && first_q && we_q;

    assign m0_gnt    = busy && first_q && !port_q;
    assign m1_gnt    = busy && first_q && port_q;
    assign m0_rvalid = resp && !port_q;
    assign m1_rvalid = resp && port_q;
    assign m0_rdata  = (resp && !port_q) ? rdata_q : 32'h0;
    assign m1_rdata  = (resp && port_q)  ? rdata_q : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (MEM_LAT=1/FAIR=1 and MEM_LAT=3/FAIR=0) checked
// every cycle against a transaction-timeline model, plus directed scenario checks.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        req   [2][2];
    logic        we    [2][2];
    logic [31:0] addr  [2][2];
    logic [31:0] wdata [2][2];
    logic [2:0]  ctrl  [2][2];
    logic        gnt   [2][2];
    logic        rv    [2][2];
    logic [31:0] rd    [2][2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic        mem_we    [2];
    logic [2:0]  mem_ctrl  [2];
    logic [31:0] mem_rdata [2];

    // Model: k = cycle index of the current access (0 = idle), timeline fixed by MEM_LAT.
    int          k      [2];
    logic        owner  [2];
    logic        last   [2];
    logic        lwe    [2];
    logic [31:0] laddr  [2];
    logic [31:0] lwdata [2];
    logic [2:0]  lctrl  [2];

    logic        gnt_seen [2][2];
    logic        pend     [2][2];
    int          we_cnt   [2];
    int          glog0[$];
    int          glog1[$];
    logic        logging = 1'b0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : ((a * 32'h9E3779B1) ^ 32'h5A5A1234);
    endfunction

    assign mem_rdata[0] = memf(mem_addr[0]);
    assign mem_rdata[1] = memf(mem_addr[1]);

    dmem_arbiter #(.MEM_LAT(1), .FAIR(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .m0_req(req[0][0]), .m0_we(we[0][0]), .m0_addr(addr[0][0]), .m0_wdata(wdata[0][0]),
        .m0_ctrl(ctrl[0][0]), .m0_gnt(gnt[0][0]), .m0_rvalid(rv[0][0]), .m0_rdata(rd[0][0]),
        .m1_req(req[0][1]), .m1_we(we[0][1]), .m1_addr(addr[0][1]), .m1_wdata(wdata[0][1]),
        .m1_ctrl(ctrl[0][1]), .m1_gnt(gnt[0][1]), .m1_rvalid(rv[0][1]), .m1_rdata(rd[0][1]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_we(mem_we[0]),
        .mem_ctrl(mem_ctrl[0]), .mem_rdata(mem_rdata[0])
    );

    dmem_arbiter #(.MEM_LAT(3), .FAIR(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .m0_req(req[1][0]), .m0_we(we[1][0]), .m0_addr(addr[1][0]), .m0_wdata(wdata[1][0]),
        .m0_ctrl(ctrl[1][0]), .m0_gnt(gnt[1][0]), .m0_rvalid(rv[1][0]), .m0_rdata(rd[1][0]),
        .m1_req(req[1][1]), .m1_we(we[1][1]), .m1_addr(addr[1][1]), .m1_wdata(wdata[1][1]),
        .m1_ctrl(ctrl[1][1]), .m1_gnt(gnt[1][1]), .m1_rvalid(rv[1][1]), .m1_rdata(rd[1][1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_we(mem_we[1]),
        .mem_ctrl(mem_ctrl[1]), .mem_rdata(mem_rdata[1])
    );

    task automatic check(input string tag, input int d, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d: observed=%h expected=%h", tag, d, obs, exp);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic model_reset(input int d);
        k[d]     = 0;
        last[d]  = 1'b1;
        owner[d] = 1'b0;
        lwe[d]   = 1'b0;
    endtask

    task automatic model_edge(input int d);
        logic g;
        if (k[d] == 0) begin
            if (req[d][0] || req[d][1]) begin
                if (req[d][0] && req[d][1]) g = (d == 0) ? !last[d] : 1'b0;
                else                        g = req[d][1];
                owner[d]  = g;
                last[d]   = g;
                lwe[d]    = we[d][g];
                laddr[d]  = addr[d][g];
                lwdata[d] = wdata[d][g];
                lctrl[d]  = ctrl[d][g];
                k[d]      = 1;
            end
        end else if (k[d] == lat_of(d) + 1) begin
            k[d] = 0;
        end else begin
            k[d] = k[d] + 1;
        end
    endtask

    task automatic check_dut(input int d);
        logic act;
        logic resp;
        logic own;
        act  = (k[d] >= 1) && (k[d] <= lat_of(d));
        resp = (k[d] == lat_of(d) + 1);
        for (int p = 0; p < 2; p++) begin
            own = (owner[d] == 1'(p));
            check($sformatf("gnt%0d", p), d, 32'(gnt[d][p]), 32'(k[d] == 1 && own));
            check($sformatf("rvalid%0d", p), d, 32'(rv[d][p]), 32'(resp && own));
            check($sformatf("rdata%0d", p), d, rd[d][p],
                  (resp && own && !lwe[d]) ? memf(laddr[d]) : 32'h0);
        end
        check("mem_addr", d, mem_addr[d], act ? laddr[d] : 32'h0);
        check("mem_wdata", d, mem_wdata[d], act ? lwdata[d] : 32'h0);
        check("mem_ctrl", d, 32'(mem_ctrl[d]), act ? 32'(lctrl[d]) : 32'h0);
        check("mem_we", d, 32'(mem_we[d]), 32'(k[d] == 1 && lwe[d]));
    endtask

    task automatic tick();
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) model_reset(d);
            else        model_edge(d);
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            check_dut(d);
            for (int p = 0; p < 2; p++) gnt_seen[d][p] = gnt[d][p];
            if (mem_we[d]) we_cnt[d]++;
        end
        if (logging) begin
            if (gnt[0][0]) glog0.push_back(0);
            if (gnt[0][1]) glog0.push_back(1);
            if (gnt[1][0]) glog1.push_back(0);
            if (gnt[1][1]) glog1.push_back(1);
        end
    endtask

    task automatic set_req(input int d, input int p, input logic w, input logic [31:0] a,
                           input logic [31:0] wd, input logic [2:0] c);
        req[d][p]   = 1'b1;
        we[d][p]    = w;
        addr[d][p]  = a;
        wdata[d][p] = wd;
        ctrl[d][p]  = c;
    endtask

    task automatic wait_gnt(input int d, input int p);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!gnt_seen[d][p] && n < 20);
        check("gnt_wait", d, 32'(gnt_seen[d][p]), 32'h1);
    endtask

    task automatic clear_all();
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) begin
                req[d][p]  = 1'b0;
                pend[d][p] = 1'b0;
            end
    endtask

    initial begin
        int n;
        int addr_cycles;
        int we0;
        for (int d = 0; d < 2; d++) begin
            model_reset(d);
            we_cnt[d] = 0;
            for (int p = 0; p < 2; p++) begin
                set_req(d, p, 1'b0, 32'h0, 32'h0, 3'h0);
                gnt_seen[d][p] = 1'b0;
                pend[d][p]     = 1'b0;
            end
        end

        // Reset held with both ports requesting: nothing may come out.
        for (int d = 0; d < 2; d++) begin
            set_req(d, 0, 1'b0, 32'h100, 32'h0, 3'h2);
            set_req(d, 1, 1'b0, 32'h200, 32'h0, 3'h2);
        end
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b1;
        tick();
        check("first_gnt_p0", 0, 32'(gnt[0][0]), 32'h1);
        check("first_gnt_p1", 0, 32'(gnt[0][1]), 32'h0);
        check("first_gnt_p0", 1, 32'(gnt[1][0]), 32'h1);
        clear_all();
        for (int i = 0; i < 6; i++) tick();

        // Single load on port 0, MEM_LAT=1.
        set_req(0, 0, 1'b0, 32'h10, 32'h0, 3'h2);
        wait_gnt(0, 0);
        req[0][0] = 1'b0;
        tick();
        check("load_rvalid", 0, 32'(rv[0][0]), 32'h1);
        check("load_rdata", 0, rd[0][0], 32'hDEADBEEF);
        for (int i = 0; i < 3; i++) tick();

        // Store on port 1: exactly one write strobe, zero read data.
        we0 = we_cnt[0];
        set_req(0, 1, 1'b1, 32'h40, 32'h12345678, 3'b010);
        wait_gnt(0, 1);
        req[0][1] = 1'b0;
        tick();
        check("store_rvalid", 0, 32'(rv[0][1]), 32'h1);
        check("store_rdata", 0, rd[0][1], 32'h0);
        for (int i = 0; i < 3; i++) tick();
        check("store_we_pulses", 0, 32'(we_cnt[0] - we0), 32'h1);

        // Both ports requesting continuously.
        logging = 1'b1;
        for (int d = 0; d < 2; d++) begin
            set_req(d, 0, 1'b0, 32'h20, 32'h0, 3'h2);
            set_req(d, 1, 1'b0, 32'h24, 32'h0, 3'h2);
        end
        for (int i = 0; i < 20; i++) tick();
        clear_all();
        logging = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("rr_grants", 0, 32'(glog0.size() >= 4), 32'h1);
        for (int i = 1; i < glog0.size(); i++)
            check("rr_alternate", 0, 32'(glog0[i]), 32'(1 - glog0[i-1]));
        check("fixed_grants", 1, 32'(glog1.size() >= 3), 32'h1);
        foreach (glog1[i]) check("fixed_port0", 1, 32'(glog1[i]), 32'h0);

        // MEM_LAT=3 load: address held three cycles, rvalid four cycles after sampling.
        we0 = we_cnt[1];
        set_req(1, 0, 1'b0, 32'h88, 32'h0, 3'h2);
        wait_gnt(1, 0);
        req[1][0] = 1'b0;
        addr_cycles = (mem_addr[1] == 32'h88) ? 1 : 0;
        n = 1;
        while (!rv[1][0] && n < 10) begin
            tick();
            n++;
            if (mem_addr[1] == 32'h88) addr_cycles++;
        end
        check("lat3_latency", 1, 32'(n), 32'd4);
        check("lat3_addr_cycles", 1, 32'(addr_cycles), 32'd3);
        check("lat3_no_we", 1, 32'(we_cnt[1] - we0), 32'h0);
        for (int i = 0; i < 3; i++) tick();

        // Reset pulsed in the second BUSY cycle of a MEM_LAT=3 store.
        set_req(1, 1, 1'b1, 32'hC0, 32'hCAFEF00D, 3'h2);
        wait_gnt(1, 1);
        req[1][1] = 1'b0;
        tick();
        rst_n = 1'b0;
        model_reset(0);
        model_reset(1);
        #1;
        check_dut(1);
        check("abort_mem_we", 1, 32'(mem_we[1]), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) tick();

        // Randomized traffic honouring the hold-until-grant contract.
        for (int c = 0; c < 400; c++) begin
            for (int d = 0; d < 2; d++)
                for (int p = 0; p < 2; p++) begin
                    if (pend[d][p] && gnt_seen[d][p]) begin
                        pend[d][p] = 1'b0;
                        req[d][p]  = 1'b0;
                    end
                    if (pend[d][p]) begin
                        if ($urandom_range(0, 15) == 0) begin
                            pend[d][p] = 1'b0;
                            req[d][p]  = 1'b0;
                        end
                    end else if ($urandom_range(0, 2) == 0) begin
                        pend[d][p] = 1'b1;
                        set_req(d, p, 1'($urandom_range(0, 1)), 32'($urandom_range(1, 63)) << 2,
                                $urandom, 3'($urandom_range(0, 7)));
                    end
                end
            tick();
        end
        clear_all();
        for (int i = 0; i < 6; i++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
